// File: rtl/lamp_pkg.sv
// Shared codes, state encoding and helpers for the lamp output stage.
package lamp_pkg;

  localparam logic [0:2] RED    = 3'b100;
  localparam logic [0:2] GREEN  = 3'b010;
  localparam logic [0:2] YELLOW = 3'b001;
  localparam logic [0:2] OFF    = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    BLANK,
    FAULT
  } state_t;

  function automatic logic is_onehot(
    input logic [0:2] c
  );
    return (c == RED) || (c == GREEN) || (c == YELLOW);
  endfunction

endpackage

// File: rtl/lamp_pwm.sv
// Free-running PWM counter and duty comparator.
module lamp_pwm #(
  parameter int PWM_BITS = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [PWM_BITS-1:0] duty,
  output logic                gate
);

  logic [PWM_BITS-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= cnt + 1'b1;
  end

  // all-ones duty must never drop the gate, even at cnt == duty
  assign gate = (&duty) | (cnt < duty);

endmodule

// File: rtl/lamp_driver.sv
// Lamp output stage: break-before-make blanking, PWM dimming and
// flashing-yellow fallback on illegal sequencer codes.
import lamp_pkg::*;

module lamp_driver #(
  parameter int BLANK_CYCLES = 4,
  parameter int PWM_BITS     = 4,
  parameter int FLASH_HALF   = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [0:2]          light_in,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                fault_clear,
  output logic [0:2]          lamp_out,
  output logic                blanking,
  output logic                fault
);

  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam int FW = $clog2(2 * FLASH_HALF) > 0 ?
                      $clog2(2 * FLASH_HALF) : 1;

  state_t          state;
  logic [0:2]      light_q;
  logic [0:2]      active_code;
  logic [BW-1:0]   bcnt;
  logic [FW-1:0]   fcnt;
  logic [FW-1:0]   fnxt;
  logic            gate;
  logic            legal;
  logic [0:2]      gmask;

  lamp_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clock  (clock),
    .reset_n(reset_n),
    .duty   (duty),
    .gate   (gate)
  );

  always_comb begin
    legal = is_onehot(light_q);
    gmask = {3{gate}};
    fnxt  = (fcnt == FW'(2 * FLASH_HALF - 1)) ? '0 : fcnt + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      light_q     <= OFF;
      active_code <= OFF;
      bcnt        <= '0;
      fcnt        <= '0;
      lamp_out    <= OFF;
      blanking    <= 1'b0;
      fault       <= 1'b0;
    end else begin
      light_q <= light_in;
      unique case (state)
        IDLE: begin
          lamp_out <= OFF;
          if (legal) begin
            active_code <= light_q;
            lamp_out    <= light_q & gmask;
            state       <= ON;
          end
        end
        ON: begin
          lamp_out <= active_code & gmask;
          if (!legal) begin
            state    <= FAULT;
            fault    <= 1'b1;
            fcnt     <= '0;
            lamp_out <= YELLOW;
          end else if (light_q != active_code) begin
            state    <= BLANK;
            bcnt     <= BW'(BLANK_CYCLES);
            blanking <= 1'b1;
            lamp_out <= OFF;
          end
        end
        BLANK: begin
          lamp_out <= OFF;
          if (!legal) begin
            state    <= FAULT;
            fault    <= 1'b1;
            blanking <= 1'b0;
            fcnt     <= '0;
            lamp_out <= YELLOW;
          end else if (bcnt == BW'(1)) begin
            active_code <= light_q;
            blanking    <= 1'b0;
            lamp_out    <= light_q & gmask;
            state       <= ON;
          end else begin
            bcnt <= bcnt - 1'b1;
          end
        end
        FAULT: begin
          blanking <= 1'b0;
          if (legal && fault_clear) begin
            fault    <= 1'b0;
            fcnt     <= '0;
            state    <= BLANK;
            bcnt     <= BW'(BLANK_CYCLES);
            blanking <= 1'b1;
            lamp_out <= OFF;
          end else begin
            fcnt     <= fnxt;
            lamp_out <= (fnxt < FW'(FLASH_HALF)) ? YELLOW : OFF;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
